// File: rtl/clmul_seq_ctrl.sv
// Sequencer for a shared 8x8 carry-less multiplier core.
// Streams all N*N byte pairs of a W x W operand pair through the core, one pair per cycle,
// and XOR-accumulates each 15-bit partial product at bit offset 8*(i+j).
module clmul_seq_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*N-1:0]   in_a,
    input  logic [8*N-1:0]   in_b,
    output logic [7:0]       core_a,
    output logic [7:0]       core_b,
    input  logic [14:0]      core_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [16*N-2:0]  out_y,
    output logic             busy
);

    localparam int unsigned W  = 8 * N;
    localparam int unsigned AW = 2 * W - 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [IW-1:0] j_q, j_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;

    logic          last_pair;
    logic          j_wrap;
    logic [IW:0]   ij_sum;
    logic [AW-1:0] pp_shifted;

    // Byte selection, partial-product alignment and next-state logic
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        j_wrap     = (j_q == IW'(N - 1));
        last_pair  = j_wrap && (i_q == IW'(N - 1));
        // Offset 8*(i+j) in bits; the sum carries one extra bit so it cannot wrap
        ij_sum     = {1'b0, i_q} + {1'b0, j_q};
        pp_shifted = AW'(core_y) << {ij_sum, 3'b000};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q ^ pp_shifted;
                if (j_wrap) begin
                    j_d = '0;
                    i_d = i_q + IW'(1);
                end else begin
                    j_d = j_q + IW'(1);
                end
                if (last_pair) begin
                    i_d     = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins over any transfer in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Handshake and core drive; core inputs parked at zero outside RUN to keep it quiet
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        out_y     = acc_q;
        if (state_q == RUN) begin
            core_a = 8'(a_q >> {i_q, 3'b000});
            core_b = 8'(b_q >> {j_q, 3'b000});
        end else begin
            core_a = 8'd0;
            core_b = 8'd0;
        end
    end

endmodule

// File: tb/tb_clmul_seq_ctrl.sv
// Scoreboard bench for clmul_seq_ctrl (N=4): models the 8x8 core, predicts products with a
// reference carry-less multiply, and checks handshake, core sequencing and results.
module tb_clmul_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic [7:0]      core_a;
    logic [7:0]      core_b;
    logic [14:0]     core_y;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [2*W-2:0]  out_y;
    logic            busy;

    logic [2*W-2:0]  exp_q[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_req = 0;
    int              n_resp = 0;
    int              out_mode = 1;   // 0: hold low, 1: hold high, 2: random
    bit              mon_en = 1'b0;

    function automatic logic [14:0] clmul8(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) if (b[k]) r = r ^ (15'(a) << k);
        return r;
    endfunction

    function automatic logic [2*W-2:0] clmul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-2:0] r;
        r = '0;
        for (int k = 0; k < W; k++) if (b[k]) r = r ^ ((2*W-1)'(a) << k);
        return r;
    endfunction

    assign core_y = clmul8(core_a, core_b);

    clmul_seq_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .core_a    (core_a),
        .core_b    (core_b),
        .core_y    (core_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Offer one operand pair and push its expected product once it is accepted
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-2:0] exp);
        bit ok;
        @(posedge clk); #1;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(exp);
            n_req++;
        end else begin
            check("send_accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Independent model of the controller, checked every cycle on the falling edge
    task automatic monitor();
        int m_state = 0;
        int m_cnt = 0;
        int nxt;
        logic [W-1:0] m_a = '0;
        logic [W-1:0] m_b = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                nxt = m_state;
                case (m_state)
                    0: begin
                        check("idle_in_ready", 64'(in_ready), 64'd1);
                        check("idle_out_valid", 64'(out_valid), 64'd0);
                        check("idle_busy", 64'(busy), 64'd0);
                        check("idle_core", 64'({core_a, core_b}), 64'd0);
                        if (in_valid) begin
                            m_a = in_a;
                            m_b = in_b;
                            m_cnt = 0;
                            nxt = 1;
                        end
                    end
                    1: begin
                        check("run_in_ready", 64'(in_ready), 64'd0);
                        check("run_out_valid", 64'(out_valid), 64'd0);
                        check("run_busy", 64'(busy), 64'd1);
                        check("run_core_a", 64'(core_a), 64'(8'(m_a >> (8 * (m_cnt / N)))));
                        check("run_core_b", 64'(core_b), 64'(8'(m_b >> (8 * (m_cnt % N)))));
                        m_cnt++;
                        if (m_cnt == N * N) nxt = 2;
                    end
                    default: begin
                        check("done_out_valid", 64'(out_valid), 64'd1);
                        check("done_in_ready", 64'(in_ready), 64'd0);
                        check("done_busy", 64'(busy), 64'd1);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL done_unrequested: got out_y %h, expected no result",
                                     out_y);
                        end else begin
                            check("done_out_y", 64'(out_y), 64'(exp_q[0]));
                        end
                        if (out_ready) begin
                            if (exp_q.size() != 0) void'(exp_q.pop_front());
                            n_resp++;
                            nxt = 0;
                        end
                    end
                endcase
                if (rst) nxt = 0;
                m_state = nxt;
            end
        end
    endtask

    task automatic drive_ready();
        forever begin
            @(posedge clk); #1;
            case (out_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0]     da[6];
        logic [W-1:0]     db[6];
        logic [2*W-2:0]   de[6];
        logic [W-1:0]     ra;
        logic [W-1:0]     rb;
        int               lat;
        int               r0;

        da[0] = 32'h0000_0087; db[0] = 32'h0000_0002; de[0] = 63'h10E;
        da[1] = 32'h0000_0001; db[1] = 32'hDEAD_BEEF; de[1] = 63'hDEAD_BEEF;
        da[2] = 32'hFFFF_FFFF; db[2] = 32'hFFFF_FFFF; de[2] = 63'h5555_5555_5555_5555;
        da[3] = 32'h8000_0000; db[3] = 32'h8000_0000; de[3] = 63'h4000_0000_0000_0000;
        da[4] = 32'h0000_0100; db[4] = 32'h0000_0100; de[4] = 63'h1_0000;
        da[5] = 32'h0300_0000; db[5] = 32'h0000_0003; de[5] = 63'h0500_0000;

        fork
            monitor();
            drive_ready();
        join_none

        // Reset
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_out_y", 64'(out_y), 64'd0);

        // Basic product and latency from the handshake edge
        send(32'h3, 32'h3, 63'h5);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'd16);
        drain();

        // Directed vectors
        for (int v = 0; v < 6; v++) send(da[v], db[v], de[v]);
        drain();

        // Backpressure: stall in DONE while junk in_valid pulses must be ignored
        out_mode = 0;
        send(32'h0000_0087, 32'h0000_0002, 63'h10E);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            in_valid = 1'((k % 2) == 0);
            in_a = $urandom;
            in_b = $urandom;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        r0 = n_resp;
        out_mode = 1;
        @(negedge clk);
        out_mode = 0;
        repeat (3) @(negedge clk);
        check("bp_one_transfer", 64'(n_resp - r0), 64'd1);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        out_mode = 1;

        // Reset at cycle 7 of RUN discards the product
        send(32'h1234_5678, 32'h9ABC_DEF0, clmul_ref(32'h1234_5678, 32'h9ABC_DEF0));
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        n_req--;
        @(negedge clk);
        check("abort_out_y", 64'(out_y), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        send(32'h0000_00FF, 32'h0000_00FF, 63'h5555);
        drain();

        // Back-to-back random traffic with random backpressure
        out_mode = 2;
        for (int v = 0; v < 100; v++) begin
            ra = $urandom;
            rb = $urandom;
            send(ra, rb, clmul_ref(ra, rb));
        end
        drain();
        out_mode = 1;
        repeat (2) @(negedge clk);
        check("req_resp_count", 64'(n_resp), 64'(n_req));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
